instruction_memory: RTL and testbench

Program store for the execution engine: the responder side of the engine's instruction-fetch interface. A host (testbench or loader) streams up to 64 nine-bit instructions (opcode[8:6], destination[5:3], source[2:0]) into internal storage. The engine then fetches by driving a 6-bit program address and receives the instruction word one cycle later. Addresses beyond the loaded program length return NO-OP, so a runaway program counter executes harmlessly.

---
 rtl/instruction_memory_if.sv | 33 +++
 rtl/instruction_memory.sv | 143 ++++++++++++++
 tb/tb_instruction_memory.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_if.sv
// Load/fetch bus between the host/engine side and the instruction memory.
interface instruction_memory_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned INST_W = 9
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  logic              load_start;
  logic              load_valid;
  logic [INST_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              load_overflow;
  logic [LEN_W-1:0]  prog_length;
  logic              ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] program_address;
  logic [INST_W-1:0] inst_mem;
  logic              inst_valid;
  logic              stop_seen;

  // Host/engine side: drives load stream and fetch requests.
  modport master (
    output load_start, load_valid, load_data, load_done, fetch_en, program_address,
    input  load_ready, load_overflow, prog_length, ready, inst_mem, inst_valid, stop_seen
  );

  // Memory side: accepts the load stream and answers fetches.
  modport slave (
    input  load_start, load_valid, load_data, load_done, fetch_en, program_address,
    output load_ready, load_overflow, prog_length, ready, inst_mem, inst_valid, stop_seen
  );
endinterface

// File: rtl/instruction_memory.sv
// Program store: streamed load of up to 64 instructions, 1-cycle registered fetch.
// Reads beyond the loaded length return NO-OP so a runaway PC is harmless.
module instruction_memory (
  input  logic                 clk,
  input  logic                 reset,
  instruction_memory_if.slave  bus
);
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned INST_W = 9;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_e;

  logic [INST_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  prog_length_q, prog_length_d;
  logic              load_ready_q, load_ready_d;
  logic              load_overflow_q, load_overflow_d;
  logic              ready_q, ready_d;
  logic [INST_W-1:0] inst_mem_q, inst_mem_d;
  logic              inst_valid_q, inst_valid_d;
  logic              stop_seen_q, stop_seen_d;

  logic              mem_we;
  logic [INST_W-1:0] rd_word;

  // Masked read: addresses at or past the program length read as NO-OP.
  always_comb begin
    rd_word = '0;
    if (LEN_W'(bus.program_address) < prog_length_q) begin
      rd_word = mem[bus.program_address];
    end
  end

  // Next-state, load bookkeeping and fetch response.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    prog_length_d   = prog_length_q;
    load_overflow_d = load_overflow_q;
    inst_mem_d      = inst_mem_q;
    inst_valid_d    = 1'b0;
    stop_seen_d     = 1'b0;
    mem_we          = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (bus.load_start) begin
          state_d         = S_LOAD;
          wr_ptr_d        = '0;
          prog_length_d   = '0;
          load_overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.load_start) begin
          wr_ptr_d        = '0;
          prog_length_d   = '0;
          load_overflow_d = 1'b0;
        end else begin
          if (bus.load_valid) begin
            if (load_ready_q) begin
              mem_we        = 1'b1;
              wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
              prog_length_d = prog_length_q + LEN_W'(1);
            end else begin
              load_overflow_d = 1'b1;
            end
          end
          if (bus.load_done) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (bus.load_start) begin
          state_d         = S_LOAD;
          wr_ptr_d        = '0;
          prog_length_d   = '0;
          load_overflow_d = 1'b0;
        end else if (bus.fetch_en) begin
          inst_mem_d   = rd_word;
          inst_valid_d = 1'b1;
          stop_seen_d  = (rd_word[INST_W-1:INST_W-3] == 3'b111);
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    load_ready_d = (state_d == S_LOAD) && (prog_length_d < LEN_W'(DEPTH));
    ready_d      = (state_d == S_READY);
  end

  // Storage write port; contents are not reset, prog_length masks stale words.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.load_data;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_EMPTY;
      wr_ptr_q        <= '0;
      prog_length_q   <= '0;
      load_ready_q    <= 1'b0;
      load_overflow_q <= 1'b0;
      ready_q         <= 1'b0;
      inst_mem_q      <= '0;
      inst_valid_q    <= 1'b0;
      stop_seen_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      prog_length_q   <= prog_length_d;
      load_ready_q    <= load_ready_d;
      load_overflow_q <= load_overflow_d;
      ready_q         <= ready_d;
      inst_mem_q      <= inst_mem_d;
      inst_valid_q    <= inst_valid_d;
      stop_seen_q     <= stop_seen_d;
    end
  end

  assign bus.load_ready    = load_ready_q;
  assign bus.load_overflow = load_overflow_q;
  assign bus.prog_length   = prog_length_q;
  assign bus.ready         = ready_q;
  assign bus.inst_mem      = inst_mem_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.stop_seen     = stop_seen_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: reference model plus fetch scoreboard.
module tb_instruction_memory;
  typedef struct packed {
    logic       valid;
    logic [8:0] data;
    logic       stop;
  } exp_t;

  logic clk;
  logic reset;

  instruction_memory_if bus ();

  instruction_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  int         addr_q[$];
  logic [8:0] model_mem [64];
  int         model_len;
  logic       model_ready;
  logic       model_ovf;
  logic [8:0] last_inst;
  int         n_checks;
  int         n_fail;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.load_start      = 1'b0;
    bus.load_valid      = 1'b0;
    bus.load_data       = '0;
    bus.load_done       = 1'b0;
    bus.fetch_en        = 1'b0;
    bus.program_address = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_len   = 0;
    model_ready = 1'b0;
    model_ovf   = 1'b0;
    last_inst   = '0;
    sb.delete();
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    model_len   = 0;
    model_ready = 1'b0;
    model_ovf   = 1'b0;
  endtask

  task automatic push_word(input logic [8:0] w, input bit done);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    bus.load_done  = done;
    step();
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
    if (model_len < 64) begin
      model_mem[model_len] = w;
      model_len++;
    end else begin
      model_ovf = 1'b1;
    end
    if (done) model_ready = 1'b1;
  endtask

  task automatic finish_load();
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    model_ready = 1'b1;
  endtask

  // Issues the fetches in addr_q back to back; scoreboard pops one cycle later.
  task automatic run_fetches();
    int   n;
    exp_t e;
    n = addr_q.size();
    for (int i = 0; i <= n; i++) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (bus.inst_valid !== e.valid) begin
          n_fail++;
          $display("FAIL fetch_valid[%0d]: got %b expected %b", i - 1, bus.inst_valid, e.valid);
        end
        n_checks++;
        if (bus.inst_mem !== e.data) begin
          n_fail++;
          $display("FAIL fetch_data[%0d]: got %b expected %b", i - 1, bus.inst_mem, e.data);
        end
        n_checks++;
        if (bus.stop_seen !== e.stop) begin
          n_fail++;
          $display("FAIL fetch_stop[%0d]: got %b expected %b", i - 1, bus.stop_seen, e.stop);
        end
      end
      if (i < n) begin
        bus.fetch_en        = 1'b1;
        bus.program_address = 6'(addr_q[i]);
        if (model_ready) begin
          e.data  = (addr_q[i] < model_len) ? model_mem[addr_q[i]] : 9'b0;
          e.valid = 1'b1;
          e.stop  = (e.data[8:6] == 3'b111);
          last_inst = e.data;
        end else begin
          e.data  = last_inst;
          e.valid = 1'b0;
          e.stop  = 1'b0;
        end
        sb.push_back(e);
      end else begin
        bus.fetch_en = 1'b0;
      end
      step();
    end
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.stop_seen !== 1'b0 || bus.inst_mem !== last_inst) begin
      n_fail++;
      $display("FAIL fetch_idle: got v=%b s=%b d=%b expected v=0 s=0 d=%b",
               bus.inst_valid, bus.stop_seen, bus.inst_mem, last_inst);
    end
    addr_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.ready, bus.inst_valid, bus.stop_seen, bus.load_ready, bus.load_overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got r=%b v=%b s=%b lr=%b ov=%b expected all 0",
               bus.ready, bus.inst_valid, bus.stop_seen, bus.load_ready, bus.load_overflow);
    end
    n_checks++;
    if (bus.inst_mem !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_inst: got %b expected 000000000", bus.inst_mem);
    end
    n_checks++;
    if (bus.prog_length !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_len: got %0d expected 0", bus.prog_length);
    end
    addr_q = '{0};
    run_fetches();
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_ready: got %b expected 0", bus.ready);
    end
  endtask

  task automatic test_basic_load();
    start_load();
    n_checks++;
    if (bus.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load_ready: got %b expected 1", bus.load_ready);
    end
    push_word(9'b001_001_000, 1'b0);
    push_word(9'b010_010_001, 1'b0);
    push_word(9'b111_000_000, 1'b0);
    finish_load();
    n_checks++;
    if (bus.ready !== 1'b1 || bus.prog_length !== 7'd3) begin
      n_fail++;
      $display("FAIL basic_ready_len: got r=%b len=%0d expected r=1 len=3", bus.ready, bus.prog_length);
    end
    addr_q = '{0, 1, 2, 3};
    run_fetches();
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 0; i < 64; i++) push_word(9'((i * 7 + 3) % 512), 1'b0);
    n_checks++;
    if (bus.load_ready !== 1'b0 || bus.prog_length !== 7'd64) begin
      n_fail++;
      $display("FAIL full_state: got lr=%b len=%0d expected lr=0 len=64", bus.load_ready, bus.prog_length);
    end
    push_word(9'h1ff, 1'b0);
    n_checks++;
    if (bus.load_overflow !== model_ovf || bus.prog_length !== 7'(model_len)) begin
      n_fail++;
      $display("FAIL overflow: got ov=%b len=%0d expected ov=%b len=%0d",
               bus.load_overflow, bus.prog_length, model_ovf, model_len);
    end
    finish_load();
    addr_q = '{63, 0, 62};
    run_fetches();
  endtask

  task automatic test_reload();
    bus.load_start      = 1'b1;
    bus.fetch_en        = 1'b1;
    bus.program_address = 6'd0;
    step();
    idle_inputs();
    model_len   = 0;
    model_ready = 1'b0;
    model_ovf   = 1'b0;
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst_mem !== last_inst) begin
      n_fail++;
      $display("FAIL dropped_fetch: got v=%b d=%b expected v=0 d=%b", bus.inst_valid, bus.inst_mem, last_inst);
    end
    n_checks++;
    if (bus.load_overflow !== 1'b0 || bus.prog_length !== 7'd0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got ov=%b len=%0d r=%b expected 0 0 0",
               bus.load_overflow, bus.prog_length, bus.ready);
    end
    for (int i = 0; i < 10; i++) push_word(9'(100 + i), 1'b0);
    start_load();
    push_word(9'b011_101_110, 1'b0);
    push_word(9'b101_010_001, 1'b0);
    finish_load();
    n_checks++;
    if (bus.prog_length !== 7'd2 || bus.load_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_len: got len=%0d ov=%b expected len=2 ov=0", bus.prog_length, bus.load_overflow);
    end
    addr_q = '{5, 0, 1};
    run_fetches();
  endtask

  task automatic test_done_same_cycle();
    start_load();
    push_word(9'b100_011_010, 1'b1);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.prog_length !== 7'd1) begin
      n_fail++;
      $display("FAIL done_same_cycle: got r=%b len=%0d expected r=1 len=1", bus.ready, bus.prog_length);
    end
    addr_q = '{0, 1};
    run_fetches();
  endtask

  task automatic test_back_to_back();
    start_load();
    for (int i = 0; i < 8; i++) begin
      push_word((i % 3 == 0) ? {3'b111, 6'($urandom_range(0, 63))} : 9'($urandom_range(0, 511)), 1'b0);
    end
    finish_load();
    for (int i = 0; i < 20; i++) addr_q.push_back(int'($urandom_range(0, 15)));
    run_fetches();
  endtask

  task automatic test_reset_mid_fetch();
    logic [8:0] exp0;
    exp0 = model_mem[0];
    bus.fetch_en        = 1'b1;
    bus.program_address = 6'd0;
    step();
    bus.fetch_en = 1'b0;
    n_checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_mem !== exp0) begin
      n_fail++;
      $display("FAIL pre_reset_fetch: got v=%b d=%b expected v=1 d=%b", bus.inst_valid, bus.inst_mem, exp0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.ready !== 1'b0 || bus.prog_length !== 7'd0 || bus.inst_mem !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_fetch_reset: got v=%b r=%b len=%0d d=%b expected 0 0 0 000000000",
               bus.inst_valid, bus.ready, bus.prog_length, bus.inst_mem);
    end
    // Reset and a fetch in the same cycle: the fetch never responds.
    do_reset();
    start_load();
    push_word(9'b010_000_001, 1'b1);
    bus.fetch_en        = 1'b1;
    bus.program_address = 6'd0;
    reset               = 1'b1;
    step();
    reset        = 1'b0;
    bus.fetch_en = 1'b0;
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_cancel: got v=%b r=%b expected v=0 r=0", bus.inst_valid, bus.ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_load();
    test_overflow();
    test_reload();
    test_done_same_cycle();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
